// File: rtl/alu_share_arbiter_if.sv
// Handshake, opcode and status bundle between the two ALU requesters, the arbiter and the ALU.
interface alu_share_arbiter_if;
    logic       req_1;
    logic [6:0] opcode_1;
    logic       ack_out_1;
    logic       req_2;
    logic [6:0] opcode_2;
    logic       ack_out_2;
    logic       req_out;
    logic       ack_in;
    logic [6:0] opcode_out;
    logic [1:0] grant_id;
    logic       busy;
    logic       err_illegal;
    logic       err_timeout;
    logic       err_clr;

    modport slave (
        input  req_1,
        input  opcode_1,
        input  req_2,
        input  opcode_2,
        input  ack_in,
        input  err_clr,
        output ack_out_1,
        output ack_out_2,
        output req_out,
        output opcode_out,
        output grant_id,
        output busy,
        output err_illegal,
        output err_timeout
    );

    modport master (
        output req_1,
        output opcode_1,
        output req_2,
        output opcode_2,
        output ack_in,
        output err_clr,
        input  ack_out_1,
        input  ack_out_2,
        input  req_out,
        input  opcode_out,
        input  grant_id,
        input  busy,
        input  err_illegal,
        input  err_timeout
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between a load/store port and an R-type port,
// with 4-phase handshakes on both sides, opcode legality check and ALU ack watchdog.
//
// state | meaning
// IDLE  | no owner; arbitrates once synced ack_in is low
// REQ   | req_out high, waiting for the ALU to ack
// ACK   | winner's ack_out high, waiting for its req to drop
// RTZ   | req_out low, waiting for the ALU ack to return to zero
module alu_share_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input logic               clk,
    input logic               rst,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        RTZ  = 2'd3
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_req_1_q, sync_req_1_d;
    logic [SYNC_STAGES-1:0] sync_req_2_q, sync_req_2_d;
    logic [SYNC_STAGES-1:0] sync_ack_q,   sync_ack_d;

    state_t     state_q, state_d;
    logic       win2_q, win2_d;
    logic       alu_req_q, alu_req_d;
    logic       last2_q, last2_d;
    logic [6:0] opcode_q, opcode_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] tmr_q, tmr_d;
    logic       err_illegal_q, err_illegal_d;
    logic       err_timeout_q, err_timeout_d;

    logic s_req_1, s_req_2, s_ack;
    logic pick2, legal, illegal_set, timeout_set, counting, changed;

    always_comb begin
        sync_req_1_d = (sync_req_1_q << 1) | SYNC_STAGES'(bus.req_1);
        sync_req_2_d = (sync_req_2_q << 1) | SYNC_STAGES'(bus.req_2);
        sync_ack_d   = (sync_ack_q   << 1) | SYNC_STAGES'(bus.ack_in);
    end

    assign s_req_1 = sync_req_1_q[SYNC_STAGES-1];
    assign s_req_2 = sync_req_2_q[SYNC_STAGES-1];
    assign s_ack   = sync_ack_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        win2_d      = win2_q;
        alu_req_d   = alu_req_q;
        last2_d     = last2_q;
        opcode_d    = opcode_q;
        grant_d     = grant_q;
        pick2       = 1'b0;
        legal       = 1'b0;
        illegal_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                if ((s_req_1 || s_req_2) && !s_ack) begin
                    // Port 2 wins when it is alone, or on a tie when port 1 was served last
                    pick2    = s_req_2 && (!s_req_1 || !last2_q);
                    win2_d   = pick2;
                    opcode_d = pick2 ? bus.opcode_2 : bus.opcode_1;
                    grant_d  = pick2 ? 2'b10 : 2'b01;
                    legal    = pick2 ? (bus.opcode_2 == OP_RTYPE)
                                     : (bus.opcode_1 == OP_LOAD || bus.opcode_1 == OP_STORE);
                    if (legal) begin
                        state_d   = REQ;
                        alu_req_d = 1'b1;
                    end else begin
                        state_d     = ACK;
                        alu_req_d   = 1'b0;
                        illegal_set = 1'b1;
                    end
                end
            end
            REQ: begin
                if (s_ack) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!(win2_q ? s_req_2 : s_req_1)) begin
                    last2_d = win2_q;
                    if (alu_req_q) begin
                        state_d = RTZ;
                    end else begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                    end
                end
            end
            RTZ: begin
                if (!s_ack) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // Watchdog: reloads on every state change, runs down only while waiting on the ALU
    always_comb begin
        counting    = (state_q == REQ) || (state_q == RTZ);
        changed     = (state_d != state_q);
        tmr_d       = tmr_q;
        timeout_set = 1'b0;
        if (changed) begin
            tmr_d = TMR_LOAD;
        end else if (counting && tmr_q != 8'd0) begin
            tmr_d       = tmr_q - 8'd1;
            timeout_set = (tmr_q == 8'd1);
        end
    end

    always_comb begin
        err_illegal_d = illegal_set || (err_illegal_q && !bus.err_clr);
        err_timeout_d = timeout_set || (err_timeout_q && !bus.err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_req_1_q  <= '0;
            sync_req_2_q  <= '0;
            sync_ack_q    <= '0;
            state_q       <= IDLE;
            win2_q        <= 1'b0;
            alu_req_q     <= 1'b0;
            last2_q       <= 1'b1;
            opcode_q      <= 7'b0;
            grant_q       <= 2'b00;
            tmr_q         <= TMR_LOAD;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            sync_req_1_q  <= sync_req_1_d;
            sync_req_2_q  <= sync_req_2_d;
            sync_ack_q    <= sync_ack_d;
            state_q       <= state_d;
            win2_q        <= win2_d;
            alu_req_q     <= alu_req_d;
            last2_q       <= last2_d;
            opcode_q      <= opcode_d;
            grant_q       <= grant_d;
            tmr_q         <= tmr_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.req_out     = (state_q == REQ) || (state_q == ACK && alu_req_q);
    assign bus.ack_out_1   = (state_q == ACK) && !win2_q;
    assign bus.ack_out_2   = (state_q == ACK) && win2_q;
    assign bus.opcode_out  = opcode_q;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: grant/opcode scoreboard plus latency, error and reset checks.
module tb_alu_share_arbiter;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

    localparam int W_REQ  = 0;
    localparam int W_ACK1 = 1;
    localparam int W_ACK2 = 2;
    localparam int W_BUSY = 3;

    typedef struct packed {
        logic [1:0] gid;
        logic [6:0] op;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    logic model_last2;

    alu_share_arbiter_if bus ();

    alu_share_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            W_REQ:   return bus.req_out;
            W_ACK1:  return bus.ack_out_1;
            W_ACK2:  return bus.ack_out_2;
            W_BUSY:  return bus.busy;
            default: return 1'bx;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic val, input string tag);
        logic got;
        got = sig(which);
        for (int i = 0; i < 400 && got !== val; i++) begin
            step(1);
            got = sig(which);
        end
        chk(tag, 32'(got), 32'(val));
    endtask

    task automatic push_exp(input int port, input logic [6:0] op);
        exp_t e;
        e.gid = (port == 1) ? 2'b01 : 2'b10;
        e.op  = op;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL %s_sb observed=grant_without_expectation expected=pending_entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_gid"}, 32'(bus.grant_id), 32'(e.gid));
        chk({tag, "_op"}, 32'(bus.opcode_out), 32'(e.op));
    endtask

    // Simultaneous request: the model decides the order from who was served last
    task automatic push_pair(input logic [6:0] op1, input logic [6:0] op2);
        if (model_last2) begin
            push_exp(1, op1);
            push_exp(2, op2);
        end else begin
            push_exp(2, op2);
            push_exp(1, op1);
        end
    endtask

    task automatic serve(input int port, input bit legal, input string tag);
        wait_sig(W_BUSY, 1'b1, {tag, "_busy"});
        pop_check(tag);
        if (legal) begin
            wait_sig(W_REQ, 1'b1, {tag, "_req"});
            bus.ack_in = 1'b1;
        end else begin
            chk({tag, "_noreq"}, 32'(bus.req_out), 32'd0);
        end
        wait_sig((port == 1) ? W_ACK1 : W_ACK2, 1'b1, {tag, "_ack"});
        chk({tag, "_ack_other"}, 32'((port == 1) ? bus.ack_out_2 : bus.ack_out_1), 32'd0);
        chk({tag, "_req_in_ack"}, 32'(bus.req_out), 32'(legal));
        if (port == 1) bus.req_1 = 1'b0;
        else           bus.req_2 = 1'b0;
        if (legal) begin
            wait_sig(W_REQ, 1'b0, {tag, "_req_drop"});
            bus.ack_in = 1'b0;
        end
        wait_sig(W_BUSY, 1'b0, {tag, "_idle"});
        chk({tag, "_gid_clr"}, 32'(bus.grant_id), 32'd0);
        model_last2 = (port == 2);
    endtask

    initial begin
        rst          = 1'b1;
        bus.req_1    = 1'b0;
        bus.req_2    = 1'b0;
        bus.opcode_1 = 7'b0;
        bus.opcode_2 = 7'b0;
        bus.ack_in   = 1'b0;
        bus.err_clr  = 1'b0;
        model_last2  = 1'b1;
        step(3);

        chk("rst_req_out", 32'(bus.req_out), 32'd0);
        chk("rst_ack1", 32'(bus.ack_out_1), 32'd0);
        chk("rst_ack2", 32'(bus.ack_out_2), 32'd0);
        chk("rst_gid", 32'(bus.grant_id), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_op", 32'(bus.opcode_out), 32'd0);
        chk("rst_errs", 32'({bus.err_illegal, bus.err_timeout}), 32'd0);
        rst = 1'b0;
        step(1);

        // Single port-1 load with exact latencies
        bus.opcode_1 = OP_LOAD;
        bus.req_1    = 1'b1;
        push_exp(1, OP_LOAD);
        step(2);
        chk("t1_req_early", 32'(bus.req_out), 32'd0);
        step(1);
        chk("t1_req_lat", 32'(bus.req_out), 32'd1);
        pop_check("t1");
        chk("t1_busy", 32'(bus.busy), 32'd1);
        step(3);
        bus.ack_in = 1'b1;
        step(2);
        chk("t1_ack_early", 32'(bus.ack_out_1), 32'd0);
        step(1);
        chk("t1_ack_lat", 32'(bus.ack_out_1), 32'd1);
        chk("t1_ack2_quiet", 32'(bus.ack_out_2), 32'd0);
        chk("t1_req_in_ack", 32'(bus.req_out), 32'd1);
        bus.req_1 = 1'b0;
        wait_sig(W_REQ, 1'b0, "t1_req_drop");
        chk("t1_rtz_ack1", 32'(bus.ack_out_1), 32'd0);
        chk("t1_rtz_gid", 32'(bus.grant_id), 32'd1);
        chk("t1_rtz_busy", 32'(bus.busy), 32'd1);
        bus.ack_in = 1'b0;
        wait_sig(W_BUSY, 1'b0, "t1_idle");
        chk("t1_gid_clr", 32'(bus.grant_id), 32'd0);
        chk("t1_no_err", 32'({bus.err_illegal, bus.err_timeout}), 32'd0);
        model_last2 = 1'b0;
        step(2);

        // Reset-state tie: port 1 first after reset happens only in test 5; here last was port 1
        bus.opcode_1 = OP_STORE;
        bus.opcode_2 = OP_RTYPE;
        bus.req_1    = 1'b1;
        bus.req_2    = 1'b1;
        push_pair(OP_STORE, OP_RTYPE);
        serve(2, 1'b1, "t2a_p2");
        step(1);
        chk("t2a_immediate", 32'(bus.grant_id), 32'd1);
        serve(1, 1'b1, "t2a_p1");
        step(2);

        bus.req_1 = 1'b1;
        bus.req_2 = 1'b1;
        push_pair(OP_STORE, OP_RTYPE);
        serve(2, 1'b1, "t2b_p2");
        serve(1, 1'b1, "t2b_p1");
        step(2);

        // Illegal opcode on port 2: no ALU request, handshake still completes
        bus.opcode_2 = OP_LOAD;
        bus.req_2    = 1'b1;
        push_exp(2, OP_LOAD);
        serve(2, 1'b0, "t3");
        chk("t3_err_ill", 32'(bus.err_illegal), 32'd1);
        bus.err_clr = 1'b1;
        step(1);
        bus.err_clr = 1'b0;
        chk("t3_err_clr", 32'(bus.err_illegal), 32'd0);
        step(2);

        // ALU never acks: watchdog fires after TIMEOUT cycles in REQ, request held
        bus.opcode_1 = OP_LOAD;
        bus.req_1    = 1'b1;
        push_exp(1, OP_LOAD);
        wait_sig(W_REQ, 1'b1, "t4_req");
        pop_check("t4");
        step(254);
        chk("t4_to_early", 32'(bus.err_timeout), 32'd0);
        step(1);
        chk("t4_to_set", 32'(bus.err_timeout), 32'd1);
        step(5);
        chk("t4_to_sticky", 32'(bus.err_timeout), 32'd1);
        chk("t4_req_held", 32'(bus.req_out), 32'd1);
        bus.ack_in = 1'b1;
        wait_sig(W_ACK1, 1'b1, "t4_late_ack");
        bus.req_1 = 1'b0;
        wait_sig(W_REQ, 1'b0, "t4_req_drop");
        bus.ack_in = 1'b0;
        wait_sig(W_BUSY, 1'b0, "t4_idle");
        model_last2 = 1'b0;
        bus.err_clr = 1'b1;
        step(1);
        bus.err_clr = 1'b0;
        chk("t4_err_clr", 32'(bus.err_timeout), 32'd0);
        step(2);

        // Reset while in ACK: outputs drop without a clock edge
        bus.req_1 = 1'b1;
        push_exp(1, OP_LOAD);
        wait_sig(W_REQ, 1'b1, "t5_req");
        pop_check("t5");
        bus.ack_in = 1'b1;
        wait_sig(W_ACK1, 1'b1, "t5_ack");
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_ack1", 32'(bus.ack_out_1), 32'd0);
        chk("t5_async_req", 32'(bus.req_out), 32'd0);
        chk("t5_async_gid", 32'(bus.grant_id), 32'd0);
        chk("t5_async_busy", 32'(bus.busy), 32'd0);
        chk("t5_async_op", 32'(bus.opcode_out), 32'd0);
        bus.req_1  = 1'b0;
        bus.ack_in = 1'b0;
        step(2);
        rst = 1'b0;
        model_last2 = 1'b1;
        step(1);
        bus.opcode_2 = OP_RTYPE;
        bus.req_1    = 1'b1;
        bus.req_2    = 1'b1;
        push_pair(OP_LOAD, OP_RTYPE);
        serve(1, 1'b1, "t5_p1");
        serve(2, 1'b1, "t5_p2");
        step(2);

        // ALU ack still high at request time blocks arbitration
        bus.ack_in = 1'b1;
        step(3);
        bus.req_1 = 1'b1;
        push_exp(1, OP_LOAD);
        step(6);
        chk("t6_blocked_busy", 32'(bus.busy), 32'd0);
        chk("t6_blocked_gid", 32'(bus.grant_id), 32'd0);
        bus.ack_in = 1'b0;
        serve(1, 1'b1, "t6");

        chk("end_sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
